// File: rtl/port_out_uart_tx_if.sv
// Word handshake between the processor output stage and the UART transmitter.
interface port_out_uart_tx_if;
    logic [31:0] WordIn;
    logic        WordValid;
    logic        WordReady;

    modport master (output WordIn, output WordValid, input WordReady);
    modport slave  (input WordIn, input WordValid, output WordReady);
endinterface

// File: rtl/port_out_uart_tx.sv
// UART 8N1 transmitter for the processor's 32-bit output word.
// One word per handshake, NUM_BYTES bytes sent LSB-byte first, LSB-bit first.
module port_out_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_BYTES    = 4
) (
    input  logic                clk,
    input  logic                reset,
    port_out_uart_tx_if.slave   bus,
    output logic                TxSerial,
    output logic                Busy,
    output logic                Done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]    LAST_BYTE = 2'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [31:0]   shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          baud_end;
    logic          accept;

    assign baud_end      = (baud_q == BAUD_MAX);
    assign bus.WordReady = (state_q == IDLE);
    assign accept        = bus.WordValid && (state_q == IDLE);
    assign TxSerial      = tx_q;
    assign Busy          = (state_q != IDLE);
    assign Done          = done_q;

    // State register; the line level is registered from the next state so it
    // changes exactly on state boundaries and has no path from WordIn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Next-state: bit timing, data shifting and byte sequencing.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    shift_d = bus.WordIn;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    // Shifting after every data bit leaves the next byte's LSB at [0].
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = START;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level for the upcoming cycle, derived from the next state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_port_out_uart_tx.sv
// Bench for port_out_uart_tx: scoreboard of expected bytes, line decoder
// checks framing and per-bit hold time, driver checks Done latency.
module tb_port_out_uart_tx;
    localparam int CPB = 4;
    localparam int NB  = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic TxSerial, Busy, Done;
    port_out_uart_tx_if bus();

    port_out_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .TxSerial(TxSerial), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] sb[$];
    int done_cnt = 0;
    int last_nz_gap = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line decoder, sampled on the falling edge.
    initial begin
        int mstate, mcyc, idle_run, b;
        logic lvl;
        logic [7:0] mbyte, e;
        mstate = 0; mcyc = 0; idle_run = 0; lvl = 1'b1; mbyte = '0;
        forever begin
            @(negedge clk);
            if (Done) begin
                done_cnt++;
                chk("done_nbusy", Busy, 0);
            end
            if (reset) begin
                mstate = 0;
                idle_run = 0;
            end else if (mstate == 0) begin
                if (TxSerial == 1'b0) begin
                    mstate = 1; mcyc = 1; lvl = 1'b0;
                    if (idle_run > 0) last_nz_gap = idle_run;
                    idle_run = 0;
                end else begin
                    idle_run++;
                end
            end else begin
                if (mcyc % CPB == 0) lvl = TxSerial;
                else chk("bit_hold", TxSerial, lvl);
                b = mcyc / CPB;
                if (b >= 1 && b <= 8 && (mcyc % CPB) == CPB / 2) mbyte[b-1] = TxSerial;
                if (mcyc == 9 * CPB) chk("stop_bit", TxSerial, 1);
                if (mcyc == FRAME - 1) begin
                    if (sb.size() == 0) chk("sb_under", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("byte", mbyte, e);
                    end
                    mstate = 0;
                end else begin
                    mcyc++;
                end
            end
        end
    end

    // Drive a word, wait for acceptance; returns in the first start-bit cycle.
    task automatic accept_word(input logic [31:0] w, input logic hold_next, input logic [31:0] nw);
        int n;
        bus.WordIn = w;
        bus.WordValid = 1'b1;
        n = 0;
        while (!bus.WordReady && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_to", (n < 2000) ? 1 : 0, 1);
        for (int k = 0; k < NB; k++) sb.push_back(w[8*k +: 8]);
        @(posedge clk); #1;
        chk("start_nxt", TxSerial, 0);
        chk("busy_start", Busy, 1);
        if (hold_next) bus.WordIn = nw;
        else           bus.WordValid = 1'b0;
    endtask

    // Count cycles from first start-bit cycle to the Done pulse.
    task automatic wait_done(input int exp);
        int n;
        logic saw_rdy;
        n = 0; saw_rdy = 1'b0;
        while (!Done && n < 2000) begin
            if (bus.WordReady) saw_rdy = 1'b1;
            @(posedge clk); #1; n++;
        end
        chk("done_lat", n, exp);
        chk("rdy_low", saw_rdy, 0);
        chk("done_busy", Busy, 0);
        chk("done_rdy", bus.WordReady, 1);
        chk("done_tx", TxSerial, 1);
    endtask

    initial begin
        int d0;
        bus.WordValid = 1'b0;
        bus.WordIn = '0;
        // Reset before any clock edge
        #1 reset = 1'b1;
        #1;
        chk("rst_tx", TxSerial, 1);
        chk("rst_rdy", bus.WordReady, 1);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Single word
        accept_word(32'h12345678, 1'b0, 32'h0);
        wait_done(NB * FRAME);
        @(posedge clk); #1;
        chk("done_1cyc", Done, 0);
        repeat (3) begin @(posedge clk); #1; end

        // Valid held while busy: second word taken on the Done cycle
        accept_word(32'h000000FF, 1'b1, 32'hA5A5A5A5);
        wait_done(NB * FRAME);
        last_nz_gap = 99;
        accept_word(32'hA5A5A5A5, 1'b0, 32'h0);
        wait_done(NB * FRAME);
        chk("gap_hold", last_nz_gap, 1);
        repeat (3) begin @(posedge clk); #1; end

        // Back-to-back
        accept_word(32'hDEADBEEF, 1'b0, 32'h0);
        wait_done(NB * FRAME);
        last_nz_gap = 99;
        accept_word(32'h00000001, 1'b0, 32'h0);
        wait_done(NB * FRAME);
        chk("gap_b2b", last_nz_gap, 1);
        repeat (3) begin @(posedge clk); #1; end

        // Reset during byte 1, data bit 3 (bit 3 of 0x56 is 0)
        accept_word(32'h12345678, 1'b0, 32'h0);
        repeat (FRAME + 4 * CPB) begin @(posedge clk); #1; end
        chk("pre_rst_tx", TxSerial, 0);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", TxSerial, 1);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_rdy", bus.WordReady, 1);
        sb.delete();
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
        repeat (200) begin @(posedge clk); #1; end
        chk("no_done", done_cnt, d0);
        accept_word(32'h00000055, 1'b0, 32'h0);
        wait_done(NB * FRAME);

        repeat (5) begin @(posedge clk); #1; end
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
